// File: rtl/pipelined_read_mux_pkg.sv
// Shared sizing helpers for the pipelined register-file read mux.
package pipelined_read_mux_pkg;

  localparam int DEF_WIDTH            = 64;
  localparam int DEF_DEPTH            = 32;
  localparam int DEF_LEVELS_PER_STAGE = 2;

  typedef int width_t;

  // Number of select bits needed to address DEPTH entries.
  function automatic width_t sel_width(input width_t depth);
    return $clog2(depth);
  endfunction

  // Pipeline depth: one register per group of LEVELS_PER_STAGE tree levels.
  function automatic width_t num_stages(input width_t selw, input width_t lps);
    return (selw + lps - 1) / lps;
  endfunction

  // The final stage absorbs whatever levels remain; may be fewer than lps.
  function automatic width_t last_stage_levels(input width_t selw, input width_t lps);
    return selw - (num_stages(selw, lps) - 1) * lps;
  endfunction

endpackage

// File: rtl/pipelined_read_mux_tree_stage.sv
// Combinational 2^LEVELS:1 reduction of N_IN words built from 2:1 word muxes.
// sel[0] picks between adjacent words, so the lowest select bit is consumed first.
module mux_tree_stage #(
  parameter int WIDTH  = 64,
  parameter int N_IN   = 4,
  parameter int LEVELS = 2
) (
  input  logic [N_IN*WIDTH-1:0]            in_words,
  input  logic [LEVELS-1:0]                sel,
  output logic [(N_IN>>LEVELS)*WIDTH-1:0]  out_words
);

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_OUT = N_IN >> (l + 1);
    logic [2*N_OUT*WIDTH-1:0] src;
    logic [N_OUT*WIDTH-1:0]   red;

    if (l == 0) begin : g_src
      assign src = in_words;
    end else begin : g_src
      assign src = g_lvl[l-1].red;
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_cell
      assign red[j*WIDTH +: WIDTH] = sel[l] ? src[(2*j+1)*WIDTH +: WIDTH]
                                            : src[(2*j)*WIDTH +: WIDTH];
    end
  end

  assign out_words = g_lvl[LEVELS-1].red;

endmodule

// File: rtl/pipelined_read_mux.sv
// Pipelined N:1 register-file read selector with valid tracking, stall/flush,
// hard-zero top entry and same-cycle write forwarding.
// The zero/bypass decision is made at capture and carried down the pipe as
// flags, then resolved in front of the output register so the array tree
// itself stays a plain mux.
module pipelined_read_mux
  import pipelined_read_mux_pkg::*;
#(
  parameter int WIDTH            = DEF_WIDTH,
  parameter int DEPTH            = DEF_DEPTH,
  parameter int LEVELS_PER_STAGE = DEF_LEVELS_PER_STAGE,
  parameter int ZERO_REG         = 1,
  parameter int BYPASS           = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [$clog2(DEPTH)-1:0]  in_sel,
  input  logic [DEPTH*WIDTH-1:0]    data_in,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(DEPTH)-1:0]  out_sel
);

  localparam int SELW              = sel_width(DEPTH);
  localparam int LPS               = LEVELS_PER_STAGE;
  localparam int L                 = num_stages(SELW, LPS);
  localparam int LAST_STAGE_LEVELS = last_stage_levels(SELW, LPS);

  for (genvar k = 0; k < L; k++) begin : g_stg
    localparam int LEV   = (k == L - 1) ? LAST_STAGE_LEVELS : LPS;
    localparam int N_IN  = DEPTH >> (k * LPS);
    localparam int N_OUT = N_IN >> LEV;

    logic                    v_in;
    logic [N_IN*WIDTH-1:0]   w_in;
    logic [SELW-1:0]         s_in;
    logic                    z_in;
    logic                    b_in;
    logic [WIDTH-1:0]        bd_in;
    logic [N_OUT*WIDTH-1:0]  w_red;
    logic                    load;

    logic                    valid_d, valid_q;
    logic [SELW-1:0]         sel_d, sel_q;
    logic [N_OUT*WIDTH-1:0]  word_d, word_q;

    if (k == 0) begin : g_src
      assign v_in  = in_valid;
      assign w_in  = data_in;
      assign s_in  = in_sel;
      assign z_in  = (ZERO_REG != 0) && (in_sel == SELW'(DEPTH - 1));
      assign b_in  = (BYPASS != 0) && wr_en && (wr_addr == in_sel);
      assign bd_in = wr_data;
    end else begin : g_src
      assign v_in  = g_stg[k-1].valid_q;
      assign w_in  = g_stg[k-1].word_q;
      assign s_in  = g_stg[k-1].sel_q;
      assign z_in  = g_stg[k-1].g_side.zero_q;
      assign b_in  = g_stg[k-1].g_side.byp_q;
      assign bd_in = g_stg[k-1].g_side.bypd_q;
    end

    mux_tree_stage #(
      .WIDTH  (WIDTH),
      .N_IN   (N_IN),
      .LEVELS (LEV)
    ) u_tree (
      .in_words  (w_in),
      .sel       (s_in[k*LPS +: LEV]),
      .out_words (w_red)
    );

    // Payload only moves with a live request, so the output holds through bubbles.
    assign load = v_in && !stall && !flush;

    // Valid bit: flush wins over stall, stall freezes, otherwise follow upstream.
    always_comb begin
      valid_d = valid_q;
      sel_d   = sel_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (!stall) begin
        valid_d = v_in;
      end
      if (load) begin
        sel_d = s_in;
      end
    end

    if (k == L - 1) begin : g_side
      // Final stage resolves zero register (highest priority) and forwarding.
      always_comb begin
        word_d = word_q;
        if (load) begin
          if (z_in) begin
            word_d = '0;
          end else if (b_in) begin
            word_d = bd_in;
          end else begin
            word_d = w_red;
          end
        end
      end
    end else begin : g_side
      logic              zero_d, zero_q;
      logic              byp_d, byp_q;
      logic [WIDTH-1:0]  bypd_d, bypd_q;

      // Intermediate stage carries the partial words and the override flags.
      always_comb begin
        word_d = word_q;
        zero_d = zero_q;
        byp_d  = byp_q;
        bypd_d = bypd_q;
        if (load) begin
          word_d = w_red;
          zero_d = z_in;
          byp_d  = b_in;
          bypd_d = bd_in;
        end
      end

      // Override flag registers.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          zero_q <= 1'b0;
          byp_q  <= 1'b0;
          bypd_q <= '0;
        end else begin
          zero_q <= zero_d;
          byp_q  <= byp_d;
          bypd_q <= bypd_d;
        end
      end
    end

    // Stage valid, select and word registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        sel_q   <= '0;
        word_q  <= '0;
      end else begin
        valid_q <= valid_d;
        sel_q   <= sel_d;
        word_q  <= word_d;
      end
    end
  end

  assign out_valid = g_stg[L-1].valid_q;
  assign out_data  = g_stg[L-1].word_q;
  assign out_sel   = g_stg[L-1].sel_q;

endmodule

// File: tb/tb_pipelined_read_mux.sv
// Bench for pipelined_read_mux: default instance against a queue-based
// reference model, plus a small L=1 instance checked with directed values.
module tb_pipelined_read_mux;

  localparam int W  = 64;
  localparam int D  = 32;
  localparam int SW = 5;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0, stall = 1'b0, flush = 1'b0, wr_en = 1'b0;
  logic [SW-1:0] in_sel = '0, wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  mem [D];
  logic [D*W-1:0] data_in;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;

  logic          s_in_valid = 1'b0, s_stall = 1'b0, s_flush = 1'b0, s_wr_en = 1'b0;
  logic [1:0]    s_in_sel = '0, s_wr_addr = '0;
  logic [7:0]    s_wr_data = '0;
  logic [31:0]   s_data_in = '0;
  logic          s_out_valid;
  logic [7:0]    s_out_data;
  logic [1:0]    s_out_sel;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < D; i++) data_in[i*W +: W] = mem[i];
  end

  pipelined_read_mux dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sel(in_sel),
    .data_in(data_in), .stall(stall), .flush(flush), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel)
  );

  pipelined_read_mux #(.WIDTH(8), .DEPTH(4), .LEVELS_PER_STAGE(2), .ZERO_REG(0), .BYPASS(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_sel(s_in_sel),
    .data_in(s_data_in), .stall(s_stall), .flush(s_flush), .wr_en(s_wr_en),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_sel(s_out_sel)
  );

  // Reference model: requests in flight, each aged by the non-stalled edges since capture.
  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    int            age;
  } fl_t;

  fl_t           q [$];
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_data = '0;
  logic [SW-1:0] m_sel = '0;
  bit            m_known = 1'b1;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;

  function automatic logic [W-1:0] expect_word(input logic [SW-1:0] sel);
    if (sel == SW'(D - 1)) return '0;
    if (wr_en && wr_addr == sel) return wr_data;
    return mem[sel];
  endfunction

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = '0;
    m_known = 1'b1;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (flush) begin
      q.delete();
      m_valid = 1'b0;
      m_known = 1'b0;
    end else if (!stall) begin
      if (q.size() > 0 && q[0].age == L) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (in_valid) q.push_back('{d: expect_word(in_sel), s: in_sel, age: 1});
      m_valid = (q.size() > 0) && (q[0].age == L);
      if (m_valid) begin
        m_data  = q[0].d;
        m_sel   = q[0].s;
        m_known = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; wr_en = 1'b0;
    in_sel = '0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < D; i++) mem[i] = 64'hA000_0000_0000_0000 + 64'(i);
    s_data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
      n_bad++;
      $display("FAIL reset: got v=%b d=%h s=%0d, expected v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
    n_cmp++;
    if (s_out_valid !== 1'b0 || s_out_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_small: got v=%b d=%h, expected v=0 d=00", s_out_valid, s_out_data);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    int nvalid = 0;
    int first  = -1;
    for (int t = 0; t < 35; t++) begin
      in_valid = (t < 31);
      in_sel   = SW'(t < 31 ? t : 0);
      tick();
      if (out_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = t + 1;
      end
      n_cmp++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== m_sel)) ||
          (!m_valid && m_known && out_data !== m_data)) begin
        n_bad++;
        $display("FAIL sweep cyc=%0d: got v=%b d=%h s=%0d, expected v=%b d=%h s=%0d",
                 cyc, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    n_cmp++;
    if (nvalid !== 31 || first !== 3) begin
      n_bad++;
      $display("FAIL sweep_count: got %0d outputs first at edge %0d, expected 31 first at edge 3", nvalid, first);
    end
  endtask

  task automatic test_zero_bypass();
    logic [SW-1:0] sels  [3] = '{5'd31, 5'd5, 5'd5};
    logic [SW-1:0] waddr [3] = '{5'd31, 5'd5, 5'd6};
    logic [W-1:0]  want  [3] = '{64'h0, 64'hDEAD, 64'hA000_0000_0000_0005};
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; in_sel = sels[n];
      wr_en = 1'b1; wr_addr = waddr[n]; wr_data = 64'hDEAD;
      tick();
      idle_inputs();
      tick();
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== want[n]) begin
        n_bad++;
        $display("FAIL zero_bypass[%0d]: got v=%b d=%h, expected v=1 d=%h", n, out_valid, out_data, want[n]);
      end
    end
    for (int t = 0; t < 60; t++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = SW'($urandom_range(0, D - 1));
      wr_en    = $urandom_range(0, 1);
      wr_addr  = ($urandom_range(0, 1) != 0) ? in_sel : SW'($urandom_range(0, D - 1));
      wr_data  = {$urandom, $urandom};
      tick();
      mem[$urandom_range(0, D - 1)] = {$urandom, $urandom};
      n_cmp++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== m_sel)) ||
          (!m_valid && m_known && out_data !== m_data)) begin
        n_bad++;
        $display("FAIL bypass_rand cyc=%0d: got v=%b d=%h s=%0d, expected v=%b d=%h s=%0d",
                 cyc, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    idle_inputs();
    repeat (L) tick();
  endtask

  task automatic test_stall();
    logic [SW-1:0] got [$];
    for (int t = 0; t < 13; t++) begin
      stall    = (t >= 2 && t < 6);
      in_valid = (t < 7);
      in_sel   = SW'(t == 0 ? 1 : (t == 1 ? 2 : 3));
      tick();
      if (out_valid === 1'b1 && !stall) got.push_back(out_sel);
      n_cmp++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== m_sel)) ||
          (!m_valid && m_known && out_data !== m_data)) begin
        n_bad++;
        $display("FAIL stall cyc=%0d: got v=%b d=%h s=%0d, expected v=%b d=%h s=%0d",
                 cyc, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
      if (t == 6) in_valid = 1'b0;
    end
    idle_inputs();
    // Sel 3 is held upstream through the stall and re-presented once, so exactly 1,2,3 emerge.
    n_cmp++;
    if (got.size() != 3 || got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3) begin
      n_bad++;
      $display("FAIL stall_order: got %0d outputs, expected sels 1,2,3 in order", got.size());
    end
  endtask

  task automatic test_flush();
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1; in_sel = SW'(7 + t);
      tick();
    end
    flush = 1'b1; stall = 1'b1; in_sel = 5'd10;
    tick();
    idle_inputs();
    for (int t = 0; t < 3; t++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flush[%0d]: got out_valid=%b, expected 0", t, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      in_sel   = SW'($urandom_range(0, D - 1));
      wr_en    = $urandom_range(0, 1);
      wr_addr  = ($urandom_range(0, 2) == 0) ? in_sel : SW'($urandom_range(0, D - 1));
      wr_data  = {$urandom, $urandom};
      tick();
      mem[$urandom_range(0, D - 1)] = {$urandom, $urandom};
      n_cmp++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== m_sel)) ||
          (!m_valid && m_known && out_data !== m_data)) begin
        n_bad++;
        $display("FAIL random cyc=%0d: got v=%b d=%h s=%0d, expected v=%b d=%h s=%0d",
                 cyc, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    idle_inputs();
    repeat (L) tick();
  endtask

  task automatic test_async_reset();
    int edges;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1; in_sel = SW'(t + 1);
      tick();
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b d=%h, expected v=0 d=0", out_valid, out_data);
    end
    model_reset();
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    in_valid = 1'b1; in_sel = 5'd12;
    tick();
    idle_inputs();
    edges = 1;
    while (out_valid !== 1'b1 && edges < 10) begin
      tick();
      edges++;
    end
    n_cmp++;
    if (edges !== L || out_data !== mem[12] || out_sel !== 5'd12) begin
      n_bad++;
      $display("FAIL reset_latency: got %0d edges d=%h s=%0d, expected %0d edges d=%h s=12",
               edges, out_data, out_sel, L, mem[12]);
    end
    repeat (2) tick();
  endtask

  task automatic test_params();
    for (int n = 0; n < 4; n++) begin
      s_in_valid = 1'b1; s_in_sel = 2'(n);
      tick();
      n_cmp++;
      if (s_out_valid !== 1'b1 || s_out_data !== 8'(8'h10 + n) || s_out_sel !== 2'(n)) begin
        n_bad++;
        $display("FAIL params sel=%0d: got v=%b d=%h s=%0d, expected v=1 d=%h s=%0d",
                 n, s_out_valid, s_out_data, s_out_sel, 8'(8'h10 + n), n);
      end
    end
    s_in_valid = 1'b0;
    tick();
    n_cmp++;
    if (s_out_valid !== 1'b0 || s_out_data !== 8'h13) begin
      n_bad++;
      $display("FAIL params_hold: got v=%b d=%h, expected v=0 d=13", s_out_valid, s_out_data);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_zero_bypass();
    test_stall();
    test_flush();
    test_random();
    test_async_reset();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
